sme_multi: RTL and testbench
============================

Name: sme_multi

Overview:
- Parametrised successor of the single-shot string matching engine; serially loads a text string and a regex-lite pattern, then scans one candidate position per clock.
- Supports '^' (word start), '$' (word end), '.' (any char) and configurable string/pattern depth.
- Adds first-match / all-matches modes, case-insensitive compare, a match counter, an explicit done pulse, and abort-on-reload.

Parameters:
- STR_MAX, 32, maximum stored string length in characters.
- PAT_MAX, 8, maximum stored pattern length, anchors included.
- IDX_W, 5, width of match_index; must be at least clog2(STR_MAX).
- CNT_W, 6, width of match_count; must be at least clog2(STR_MAX+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- chardata  in  8  character byte, sampled when isstring or ispattern is 1.
- isstring  in  1  string load strobe, one character per cycle.
- ispattern  in  1  pattern load strobe, one character per cycle.
- find_all  in  1  match mode, sampled on the job-start cycle: 0 = first match only, 1 = all matches.
- nocase  in  1  case-fold A-Z/a-z for compare, sampled on the job-start cycle.
- valid  out  1  one-cycle result strobe.
- match  out  1  qualified by valid.
- match_index  out  IDX_W  0-based string index of the first character matched by the non-anchor pattern core.
- match_count  out  CNT_W  matches found so far in the current job; held after done.
- done  out  1  one-cycle end-of-job strobe.

Behaviour:
- Reset (clk edge with reset=1):
  - valid, match, done = 0; match_index, match_count = 0.
  - Stored string length = 0, stored pattern length = 0; state = IDLE.
- States and transitions:
  - IDLE -> LOAD on isstring or ispattern.
  - LOAD -> SCAN on the first cycle with both strobes low (the job-start cycle).
  - SCAN -> DONE when the last candidate position has been evaluated, or on the first match when find_all=0.
  - DONE -> IDLE after one cycle.
- Loading:
  - A rising isstring restarts string length at 0; a rising ispattern does the same for the pattern. Either is judged against that strobe's value in the previous cycle.
  - A job that loads only a new pattern reuses the stored string, and vice versa.
  - isstring and ispattern both high: isstring wins and the pattern byte is dropped.
  - Bytes beyond STR_MAX or PAT_MAX are dropped; the corresponding length saturates.
- Pattern decode, latched on the job-start cycle:
  - pattern[0]=8'h5E ('^') sets anchor_start.
  - pattern[len-1]=8'h24 ('$') sets anchor_end.
  - core = the remaining characters; core length k.
  - 8'h2E ('.') in the core matches any byte, including space.
- Candidate position p, scanned from 0 up to strlen-k, one p per SCAN cycle. p matches when all of:
  - every core byte equals string[p+i] (after case-fold if nocase);
  - if anchor_start: p==0 or string[p-1]==8'h20;
  - if anchor_end: p+k==strlen or string[p+k]==8'h20.
- Latency:
  - Job-start cycle = L. Position p is evaluated in cycle L+1+p.
  - Its result is registered and visible in cycle L+2+p.
- Outputs per mode:
  - find_all=0, match found: valid=1, match=1, match_index=p, match_count=1 and done=1, all in the same cycle; the scan stops.
  - find_all=0, no match: valid=1, match=0, match_index=0, done=1 in the cycle after the last evaluation.
  - find_all=1: one valid=1, match=1, match_index=p pulse per matching p, with match_count incremented in the same cycle. After the last position comes a final cycle with valid=1, match=0, done=1 and match_count = total.
- No-match boundaries: k=0 (anchors only), k>strlen, or strlen=0 give no match, reported as a single valid+done with match=0 in cycle L+2.
- Abort: isstring or ispattern asserted during SCAN aborts the scan.
  - No done is issued; valid=0 from the next cycle; state -> LOAD.
  - The byte is captured as the first character of a new load.
- match_count clears on the job-start cycle. reset in any state overrides everything.

Test Plan:
- String "hello world", pattern "wor", find_all=0 -> one valid with match=1, match_index=6, done=1 in cycle L+8.
- Same string, pattern "^wor" -> index 6; pattern "^orl" -> match=0 with done.
- Same string, pattern "l.o$" -> index 2; pattern "l.o" with find_all=1 -> one match pulse, index 2, then the done cycle with match_count=1.
- String "Hello World", pattern "o" -> with find_all=1: matches at indices 4 and 7, final match_count=2. Pattern "world" with nocase=1 -> index 6; with nocase=0 -> match=0.
- Load 40 string bytes with STR_MAX=32 -> length saturates at 32. Pattern "$" alone -> immediate match=0 with done in cycle L+2.
- isstring raised mid-SCAN -> no done, no further valid, new string stored. Reset mid-LOAD -> all outputs 0 and stored lengths 0 on the next cycle.

Source files
------------

// File: rtl/sme_multi.sv
// sme_multi: regex-lite string matching engine.
// Text and pattern are loaded serially, one byte per cycle. A job then scans one
// candidate start position per clock. Supports '^' (word start), '$' (word end),
// '.' (any byte), optional case folding, first-match / all-matches modes, a match
// counter, an explicit done strobe and abort-on-reload.
module sme_multi #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  input  logic             find_all,
  input  logic             nocase,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  // Address widths for the byte stores and widths for the stored lengths.
  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);

  localparam logic [7:0] ChCaret  = 8'h5E;
  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChDot    = 8'h2E;
  localparam logic [7:0] ChSpace  = 8'h20;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StScan = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Map A-Z onto a-z when folding is enabled; all other bytes pass through.
  function automatic logic [7:0] fold(input logic [7:0] b, input logic en);
    if (en && (b >= 8'h41) && (b <= 8'h5A)) return b | 8'h20;
    return b;
  endfunction

  // Byte stores and load bookkeeping.
  logic [7:0]     str_mem [STR_MAX];
  logic [7:0]     pat_mem [PAT_MAX];
  logic [SLW-1:0] str_len_q, str_len_d;
  logic [PLW-1:0] pat_len_q, pat_len_d;
  logic           str_prev_q, pat_prev_q;
  logic           str_restart, str_wr;
  logic           pat_take, pat_restart, pat_wr;
  logic [SAW-1:0] str_waddr;
  logic [PAW-1:0] pat_waddr;

  // Job configuration latched on the job-start cycle.
  logic [7:0]     core_d [PAT_MAX];
  logic [7:0]     core_q [PAT_MAX];
  logic [PLW-1:0] core_len_d, core_len_q;
  logic           anc_start_d, anc_start_q;
  logic           anc_end_d, anc_end_q;
  logic           all_q, fold_q;
  logic           job_start;

  // Scan control and registered outputs.
  logic [1:0]       state_q, state_d;
  logic [SLW-1:0]   pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             strobe;

  int unsigned pos_i, k_i, len_i, last_i;
  logic        hit, empty_job;

  assign strobe = isstring | ispattern;

  // Load path: a rising strobe restarts its buffer, otherwise bytes append until full.
  // When both strobes are high the string wins and the pattern byte is dropped.
  always_comb begin
    str_restart = isstring && !str_prev_q;
    str_wr      = isstring && (str_restart || (str_len_q < SLW'(STR_MAX)));
    str_waddr   = str_restart ? '0 : SAW'(str_len_q);
    str_len_d   = str_len_q;
    if (str_restart) begin
      str_len_d = SLW'(1);
    end else if (str_wr) begin
      str_len_d = str_len_q + SLW'(1);
    end

    pat_take    = ispattern && !isstring;
    pat_restart = pat_take && !pat_prev_q;
    pat_wr      = pat_take && (pat_restart || (pat_len_q < PLW'(PAT_MAX)));
    pat_waddr   = pat_restart ? '0 : PAW'(pat_len_q);
    pat_len_d   = pat_len_q;
    if (pat_restart) begin
      pat_len_d = PLW'(1);
    end else if (pat_wr) begin
      pat_len_d = pat_len_q + PLW'(1);
    end
  end

  // Pattern decode: strip anchors and pre-fold the core so the scan compares directly.
  always_comb begin
    job_start   = (state_q == StLoad) && !isstring && !ispattern;
    anc_start_d = (pat_len_q != '0) && (pat_mem[0] == ChCaret);
    anc_end_d   = (pat_len_q != '0) && (pat_mem[PAW'(pat_len_q - PLW'(1))] == ChDollar);
    core_len_d  = pat_len_q - PLW'(anc_start_d) - PLW'(anc_end_d);
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      core_d[i] = 8'h00;
      if (i + 32'(anc_start_d) < PAT_MAX) begin
        core_d[i] = fold(pat_mem[PAW'(i + 32'(anc_start_d))], nocase);
      end
    end
  end

  // Evaluate the current candidate position against core and anchors.
  always_comb begin
    pos_i     = 32'(pos_q);
    k_i       = 32'(core_len_q);
    len_i     = 32'(str_len_q);
    empty_job = (k_i == 0) || (k_i > len_i);
    last_i    = empty_job ? 0 : len_i - k_i;
    hit       = 1'b1;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      if (i < k_i) begin
        if (pos_i + i >= STR_MAX) begin
          hit = 1'b0;
        end else if ((core_q[i] != ChDot) &&
                     (fold(str_mem[SAW'(pos_i + i)], fold_q) != core_q[i])) begin
          hit = 1'b0;
        end
      end
    end
    if (anc_start_q && (pos_i != 0)) begin
      if (str_mem[SAW'(pos_i - 1)] != ChSpace) hit = 1'b0;
    end
    if (anc_end_q && (pos_i + k_i != len_i)) begin
      if (pos_i + k_i >= STR_MAX) begin
        hit = 1'b0;
      end else if (str_mem[SAW'(pos_i + k_i)] != ChSpace) begin
        hit = 1'b0;
      end
    end
  end

  // Job FSM and next values of the result strobes.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    match_d = 1'b0;
    done_d  = 1'b0;
    index_d = index_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (strobe) state_d = StLoad;
      end
      StLoad: begin
        if (job_start) begin
          state_d = StScan;
          pos_d   = '0;
          count_d = '0;
        end
      end
      StScan: begin
        if (strobe) begin
          // Reload aborts silently; the byte already went into the store.
          state_d = StLoad;
        end else if (empty_job || (pos_i > last_i)) begin
          // Nothing to scan, or the all-matches epilogue after the last position.
          valid_d = 1'b1;
          done_d  = 1'b1;
          index_d = '0;
          state_d = StDone;
        end else if (hit) begin
          valid_d = 1'b1;
          match_d = 1'b1;
          index_d = IDX_W'(pos_i);
          count_d = count_q + CNT_W'(1);
          if (!all_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            pos_d = pos_q + SLW'(1);
          end
        end else if (!all_q && (pos_i == last_i)) begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          index_d = '0;
          state_d = StDone;
        end else begin
          pos_d = pos_q + SLW'(1);
        end
      end
      StDone: begin
        state_d = strobe ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control, configuration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      str_prev_q  <= 1'b0;
      pat_prev_q  <= 1'b0;
      pos_q       <= '0;
      core_len_q  <= '0;
      anc_start_q <= 1'b0;
      anc_end_q   <= 1'b0;
      all_q       <= 1'b0;
      fold_q      <= 1'b0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      index_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q    <= state_d;
      str_len_q  <= str_len_d;
      pat_len_q  <= pat_len_d;
      str_prev_q <= isstring;
      pat_prev_q <= ispattern;
      pos_q      <= pos_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      done_q     <= done_d;
      index_q    <= index_d;
      count_q    <= count_d;
      if (job_start) begin
        core_len_q  <= core_len_d;
        anc_start_q <= anc_start_d;
        anc_end_q   <= anc_end_d;
        all_q       <= find_all;
        fold_q      <= nocase;
      end
    end
  end

  // Byte stores and latched pattern core; contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (!reset && str_wr) str_mem[str_waddr] <= chardata;
    if (!reset && pat_wr) pat_mem[pat_waddr] <= chardata;
    if (!reset && job_start) begin
      for (int unsigned i = 0; i < PAT_MAX; i++) core_q[i] <= core_d[i];
    end
  end

  assign valid       = valid_q;
  assign match       = match_q;
  assign done        = done_q;
  assign match_index = index_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_sme_multi.sv
// tb_sme_multi: directed table-driven bench for sme_multi plus hand-written
// sequences for saturation, abort-on-reload and reset during load.
module tb_sme_multi;

  logic       clk;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       find_all;
  logic       nocase;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic [5:0] match_count;
  logic       done;

  sme_multi dut (
    .clk        (clk),
    .reset      (reset),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .find_all   (find_all),
    .nocase     (nocase),
    .valid      (valid),
    .match      (match),
    .match_index(match_index),
    .match_count(match_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string s;        // empty = reuse stored string
    string p;
    bit    fa;
    bit    nc;
    int    exp_idx;  // first match index
    int    exp_idx2; // second match index (all-matches rows)
    int    exp_cnt;  // number of matches / final match_count
    int    exp_k;    // done cycle relative to job start
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Observation results of one job.
  int n_valid, n_match, idx_a, idx_b, fin_v, fin_m, fin_cnt, fin_idx, done_k, bad_cnt;

  function automatic vec_t mk(input string s, input string p, input bit fa, input bit nc,
                              input int ei, input int ei2, input int ec, input int ek);
    vec_t v;
    v.s = s; v.p = p; v.fa = fa; v.nc = nc;
    v.exp_idx = ei; v.exp_idx2 = ei2; v.exp_cnt = ec; v.exp_k = ek;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_bytes(input string s, input bit is_str);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      chardata  = s[i];
      isstring  = is_str;
      ispattern = !is_str;
    end
  endtask

  // Drop the strobes (job-start cycle L) and watch up to 60 cycles for done.
  task automatic start_and_observe(input bit fa, input bit nc);
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    find_all  = fa;
    nocase    = nc;
    n_valid = 0; n_match = 0; idx_a = -1; idx_b = -1;
    fin_v = 0; fin_m = 0; fin_cnt = -1; fin_idx = -1; done_k = 0; bad_cnt = 0;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      if (valid) begin
        n_valid++;
        if (match) begin
          if (n_match == 0) idx_a = int'(match_index);
          else if (n_match == 1) idx_b = int'(match_index);
          n_match++;
          if (int'(match_count) != n_match) bad_cnt++;
        end
      end
      if (done) begin
        done_k  = k;
        fin_v   = int'(valid);
        fin_m   = int'(match);
        fin_cnt = int'(match_count);
        fin_idx = int'(match_index);
      end
    end
  endtask

  task automatic check_outputs_idle(input string name);
    check({name, "_valid"}, int'(valid), 0);
    check({name, "_match"}, int'(match), 0);
    check({name, "_index"}, int'(match_index), 0);
    check({name, "_count"}, int'(match_count), 0);
    check({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    reset = 1'b1; chardata = 8'h00; isstring = 1'b0; ispattern = 1'b0;
    find_all = 1'b0; nocase = 1'b0;

    //           string         pattern  fa nc idx idx2 cnt k
    vecs.push_back(mk("hello world", "wor",   0, 0, 6, 0, 1, 8));
    vecs.push_back(mk("",            "^wor",  0, 0, 6, 0, 1, 8));
    vecs.push_back(mk("",            "^orl",  0, 0, 0, 0, 0, 10));
    vecs.push_back(mk("",            "l.o$",  0, 0, 2, 0, 1, 4));
    vecs.push_back(mk("",            "l.o",   1, 0, 2, 0, 1, 11));
    vecs.push_back(mk("Hello World", "o",     1, 0, 4, 7, 2, 13));
    vecs.push_back(mk("",            "world", 0, 1, 6, 0, 1, 8));
    vecs.push_back(mk("",            "world", 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk("",            "$",     0, 0, 0, 0, 0, 2));
    vecs.push_back(mk("Hi",          "hello", 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk("ab ab",       "^ab$",  1, 0, 0, 3, 2, 6));

    repeat (2) @(negedge clk);
    check_outputs_idle("reset");
    reset = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].s.len() != 0) load_bytes(vecs[r].s, 1'b1);
      load_bytes(vecs[r].p, 1'b0);
      start_and_observe(vecs[r].fa, vecs[r].nc);
      check($sformatf("row%0d_done_cycle", r), done_k, vecs[r].exp_k);
      check($sformatf("row%0d_done_valid", r), fin_v, 1);
      check($sformatf("row%0d_valid_pulses", r), n_valid,
            vecs[r].fa ? vecs[r].exp_cnt + 1 : 1);
      check($sformatf("row%0d_match_pulses", r), n_match, vecs[r].exp_cnt);
      check($sformatf("row%0d_count_final", r), fin_cnt, vecs[r].exp_cnt);
      check($sformatf("row%0d_count_step", r), bad_cnt, 0);
      check($sformatf("row%0d_done_match", r), fin_m,
            (!vecs[r].fa && vecs[r].exp_cnt > 0) ? 1 : 0);
      if (vecs[r].exp_cnt > 0)
        check($sformatf("row%0d_index_first", r), idx_a, vecs[r].exp_idx);
      if (vecs[r].exp_cnt > 1)
        check($sformatf("row%0d_index_second", r), idx_b, vecs[r].exp_idx2);
      if (!vecs[r].fa && vecs[r].exp_cnt == 0)
        check($sformatf("row%0d_nomatch_index", r), fin_idx, 0);
    end

    // Saturation: 40 bytes loaded, only the first 32 kept ('a'x31, 'b', then 'c'x8).
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      isstring  = 1'b1;
      ispattern = 1'b0;
      chardata  = (i < 31) ? 8'h61 : ((i == 31) ? 8'h62 : 8'h63);
    end
    load_bytes("b$", 1'b0);
    start_and_observe(1'b0, 1'b0);
    check("sat_b_done_cycle", done_k, 33);
    check("sat_b_match", fin_m, 1);
    check("sat_b_index", fin_idx, 31);
    load_bytes("c", 1'b0);
    start_and_observe(1'b0, 1'b0);
    check("sat_c_done_cycle", done_k, 33);
    check("sat_c_match", fin_m, 0);
    check("sat_c_valid_pulses", n_valid, 1);

    // Abort: reload the string three positions into a scan for "d".
    load_bytes("hello world", 1'b1);
    load_bytes("d", 1'b0);
    @(negedge clk);
    isstring = 1'b0; ispattern = 1'b0; find_all = 1'b0; nocase = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_pre%0d_valid_done", k), int'({valid, done}), 0);
    end
    isstring = 1'b1;
    chardata = 8'h78;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_load%0d_valid_done", i), int'({valid, done}), 0);
      chardata = (i == 0) ? 8'h78 : 8'h64;
    end
    start_and_observe(1'b0, 1'b0);
    check("abort_new_done_cycle", done_k, 4);
    check("abort_new_match", fin_m, 1);
    check("abort_new_index", fin_idx, 2);
    check("abort_new_valid_pulses", n_valid, 1);

    // Reset in the middle of a string load clears outputs and stored lengths.
    @(negedge clk); isstring = 1'b1; chardata = 8'h61;
    @(negedge clk); chardata = 8'h62;
    @(negedge clk); reset = 1'b1; chardata = 8'h63;
    @(negedge clk); reset = 1'b0; isstring = 1'b0;
    check_outputs_idle("midload_reset");
    load_bytes("a", 1'b0);
    start_and_observe(1'b0, 1'b0);
    check("midload_empty_done_cycle", done_k, 2);
    check("midload_empty_match", fin_m, 0);
    check("midload_empty_count", fin_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
